ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Valid/ready front-end for the single-port synchronous-read `ram` block, sitting directly upstream of it. It accepts read/write requests from a core or bus master and drives the RAM address, write-data and write-enable ports. It captures the RAM's one-cycle-latency read data into a 2-entry response buffer, so back-pressure on the response side never loses data. Optionally, it zero-fills the whole memory after reset before accepting traffic.

## Interface

- `XLen`, 32: data word width; must equal the RAM's `XLen`.
- `NPos`, 1024: number of RAM words; must equal the RAM's `NPos`.
- `AddrWidth` (localparam), `$clog2(NPos)`: address width.

- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in AddrWidth: word address.
- `req_wdata_i` in XLen: write data; ignored for reads.
- `rsp_valid_o` out 1: read response valid.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_rdata_o` out XLen: read data.
- `init_done_o` out 1: controller is in RUN.
- `ram_a_o` out AddrWidth: drives RAM `a_i`.
- `ram_wd_o` out XLen: drives RAM `wd_i`.
- `ram_we_o` out 1: drives RAM `we_i`.
- `ram_rd_i` in XLen: from RAM `rd_o`.

## Operation

**States**
- INIT: zero-fill sweep. Present only with the macro.
- RUN: normal traffic.
- Reset value: INIT if `RAM_CTRL_INIT_EN` is defined, else RUN.

**INIT**
- Counter `ic` runs 0..NPos-1, one word per cycle.
- RAM drive: `ram_we_o`=1, `ram_a_o`=`ic`, `ram_wd_o`=0.
- Outputs: `req_ready_o`=0, `init_done_o`=0.
- Transition: when `ic`=NPos-1, go to RUN on the next edge.

**RUN**
- Outstanding counter `oc` (0..2) counts accepted reads not yet popped from the response buffer.
- `req_ready_o` = (state==RUN) && (`oc`<2). It applies to reads and writes alike, which preserves ordering.
- `req_ready_o` is derived from registers only; there is no combinational path from `rsp_ready_i` or `req_valid_i`.

**RAM drive**
- Combinational from the request: `ram_a_o`=`req_addr_i`, `ram_wd_o`=`req_wdata_i`.
- `ram_we_o` = accept && `req_we_i`.
- When no request is accepted, `ram_we_o`=0.

**Requests**
- A write completes at the accept edge and produces no response.
- A read sets the `pend` flag at the accept edge.
- On the cycle after accept (`pend`=1), `ram_rd_i` is pushed into the response buffer.

**Response buffer**
- 2-entry FIFO, in order.
- Pop on `rsp_valid_o` && `rsp_ready_i`.
- `rsp_rdata_o` = head entry; it holds stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- Overflow is impossible by construction (`oc`≤2).

**Counter `oc` update**
- +1 on read accept, −1 on pop.
- Both in the same cycle: unchanged.

**Reset mid-operation**
- `rst_ni` low clears state, `ic`, `oc`, `pend` and the FIFO.
- In-flight reads are discarded; a partial INIT sweep restarts from 0.
- RAM contents are not otherwise touched.

## Timing

**Reset values**
- `req_ready_o`: 1 without macro, 0 with macro.
- `rsp_valid_o`=0, `rsp_rdata_o`=0.
- `init_done_o`: 1 without macro, 0 with macro.
- `ram_we_o`: 0 without macro. With the macro, 1 during INIT: the zero-fill sweep writes address 0 while `rst_ni` is held low.

**Latency and throughput**
- Read accepted in cycle N → RAM samples at the end of N → pushed at the end of N+1 → `rsp_valid_o`=1 in cycle N+2.
- Sustained reads with `rsp_ready_i`=1: 2 accepts per 3 cycles.
- Writes: 1 per cycle.

**INIT duration**
- Exactly NPos cycles after reset release; `init_done_o` rises in cycle NPos.

**Same-address hazards**
- Write-then-read to the same address in back-to-back cycles returns the new data.
- This holds because the RAM is written at the write's accept edge.

## Configuration

- `RAM_CTRL_INIT_EN` defined: the INIT state and `ic` counter are compiled in, and memory is zero-filled after every reset.
- Undefined: no INIT state, `init_done_o` tied to 1, and RAM contents after reset are undefined.

## Structure

- Package `ram_ctrl_pkg`:
  - `ctrl_state_e` enum {INIT, RUN}.
  - Localparam `RspDepth`=2.
  - Width of `oc` (2 bits).
- Sub-module `ram_ctrl_rsp_fifo`:
  - Parameterised `XLen` × `RspDepth` FIFO with push/pop/valid.
  - Reset on `rst_ni`.
  - Instantiated once.

## Test plan

- **Macro defined, NPos=16, reset release:** `init_done_o`=0 and `req_ready_o`=0 for 16 cycles with `ram_we_o`=1 over addresses 0..15; then read address 5 → `rsp_rdata_o`=0.
- **Write then read:** write 0xDEADBEEF to address 3 in cycle N, read address 3 in N+1 → `rsp_valid_o`=1 in N+3 with 0xDEADBEEF.
- **Back-pressure:** `rsp_ready_i`=0 and three reads offered to addresses 1, 2, 3 holding 0x11, 0x22, 0x33 → only two accepted and `req_ready_o`=0. Raise `rsp_ready_i` → responses 0x11, 0x22, then 0x33, in order, with no loss.
- **Streaming reads:** `rsp_ready_i`=1, 6 consecutive read requests → accepted at a 2-of-3-cycle rate; 6 responses in address order.
- **Reset mid-INIT:** pull `rst_ni` low at `ic`=7 → after release, the sweep restarts at address 0 and `init_done_o` rises NPos cycles later.
- **Reset with responses buffered:** hold 2 entries in the buffer, assert `rst_ni` low → `rsp_valid_o`=0 immediately; no stale response after release.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing for the ram_ctrl front-end.
//   ctrl_state_e : controller state (INIT zero-fill sweep, RUN normal traffic)
//   RspDepth     : response buffer depth
//   oc_t         : outstanding-read counter type (0..RspDepth)
package ram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int unsigned RspDepth = 2;
    localparam int unsigned OcWidth  = 2;

    typedef logic [OcWidth-1:0] oc_t;

endpackage

// File: rtl/ram_ctrl_rsp_fifo.sv
// In-order response buffer holding RAM read data until the consumer takes it.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (clears pointers and storage)
//   push_i        : write push_data_i at the tail
//   push_data_i   : data to store
//   pop_i         : drop the head entry (caller gates with valid_o)
//   valid_o       : at least one entry present
//   data_o        : head entry, stable until popped
module ram_ctrl_rsp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned XLen = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [XLen-1:0] push_data_i,
    input  logic            pop_i,
    output logic            valid_o,
    output logic [XLen-1:0] data_o
);

    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);

    logic [XLen-1:0]     mem [RspDepth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] cnt;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Storage, pointers and occupancy; storage is cleared so data_o reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RspDepth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_i) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_i, pop_i})
                2'b10:   cnt <= cnt + CntWidth'(1);
                2'b01:   cnt <= cnt - CntWidth'(1);
                default: ;
            endcase
        end
    end

    assign valid_o = (cnt != '0);
    assign data_o  = mem[rd_ptr];

endmodule

// File: rtl/ram_ctrl.sv
// Valid/ready front-end for a single-port synchronous-read RAM.
// Accepts read/write requests, drives the RAM ports, and buffers the
// one-cycle-latency read data in a 2-entry in-order response FIFO.
// Optional macro RAM_CTRL_INIT_EN: zero-fill the whole RAM after each reset
// before accepting traffic.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   req_valid_i/req_ready_o       : request handshake
//   req_we_i, req_addr_i, req_wdata_i : request payload (write data ignored for reads)
//   rsp_valid_o/rsp_ready_i       : read response handshake
//   rsp_rdata_o                   : read response data
//   init_done_o                   : controller is in RUN
//   ram_a_o, ram_wd_o, ram_we_o   : RAM address / write data / write enable
//   ram_rd_i                      : RAM read data (one cycle after address)
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter  int unsigned XLen      = 32,
    parameter  int unsigned NPos      = 1024,
    localparam int unsigned AddrWidth = $clog2(NPos)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [XLen-1:0]      req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [XLen-1:0]      rsp_rdata_o,
    output logic                 init_done_o,
    output logic [AddrWidth-1:0] ram_a_o,
    output logic [XLen-1:0]      ram_wd_o,
    output logic                 ram_we_o,
    input  logic [XLen-1:0]      ram_rd_i
);

    ctrl_state_e state;
    oc_t         oc;
    logic        pend;
    logic        accept;
    logic        rd_accept;
    logic        pop;
    logic        fifo_valid;

`ifdef RAM_CTRL_INIT_EN
    logic [AddrWidth-1:0] ic;

    // Zero-fill sweep: one word per cycle, then hand over to RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= INIT;
            ic    <= '0;
        end else begin
            case (state)
                INIT: begin
                    ic <= ic + AddrWidth'(1);
                    if (ic == AddrWidth'(NPos - 1)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
`else
    assign state = RUN;
`endif

    // Ready comes only from registers; it gates writes too so order is preserved.
    assign req_ready_o = (state == RUN) && (oc < oc_t'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;
    assign rd_accept   = accept && !req_we_i;
    assign pop         = fifo_valid && rsp_ready_i;
    assign init_done_o = (state == RUN);
    assign rsp_valid_o = fifo_valid;

    // RAM drive: pass the request through; the INIT sweep overrides it.
    always_comb begin
        ram_a_o  = req_addr_i;
        ram_wd_o = req_wdata_i;
        ram_we_o = accept && req_we_i;
`ifdef RAM_CTRL_INIT_EN
        if (state == INIT) begin
            ram_a_o  = ic;
            ram_wd_o = '0;
            ram_we_o = 1'b1;
        end
`endif
    end

    // pend marks the cycle the RAM read data is valid; oc bounds in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend <= 1'b0;
            oc   <= '0;
        end else begin
            pend <= rd_accept;
            case ({rd_accept, pop})
                2'b10:   oc <= oc + oc_t'(1);
                2'b01:   oc <= oc - oc_t'(1);
                default: ;
            endcase
        end
    end

    ram_ctrl_rsp_fifo #(
        .XLen (XLen)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (pend),
        .push_data_i (ram_rd_i),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (rsp_rdata_o)
    );

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl with a behavioural RAM and a
// transaction-level reference model (memory image + queue of expected reads).
module tb_ram_ctrl;

    localparam int unsigned XLen = 32;
    localparam int unsigned NPos = 16;
    localparam int unsigned AW   = $clog2(NPos);

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [XLen-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLen-1:0] rsp_rdata;
    logic            init_done;
    logic [AW-1:0]   ram_a;
    logic [XLen-1:0] ram_wd;
    logic            ram_we;
    logic [XLen-1:0] ram_rd;

    ram_ctrl #(
        .XLen (XLen),
        .NPos (NPos)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .init_done_o (init_done),
        .ram_a_o     (ram_a),
        .ram_wd_o    (ram_wd),
        .ram_we_o    (ram_we),
        .ram_rd_i    (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read RAM.
    logic [XLen-1:0] mem [NPos];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_wd;
        ram_rd <= mem[ram_a];
    end

    // Reference model state.
    typedef struct {
        logic [XLen-1:0] d;
        int              due;
    } exp_t;

    logic [XLen-1:0] ref_mem [NPos];
    exp_t            q[$];
    int              cyc;
    int              n_checks;
    int              n_errors;
    int              n_obs_acc;
    logic            last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check outputs, then advance the model.
    task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [XLen-1:0] wd, input logic rr);
        logic exp_rdy;
        logic exp_rv;
        logic acc;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = rr;
        #1;
        exp_rdy = (q.size() < 2);
        exp_rv  = (q.size() > 0) && (q[0].due <= cyc);
        acc     = v && exp_rdy;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) check("rsp_rdata", rsp_rdata, q[0].d);
        check("ram_we", 32'(ram_we), 32'(acc && we));
        if (acc) check("ram_a", 32'(ram_a), 32'(a));
        if (acc && we) check("ram_wd", ram_wd, wd);
        if (req_valid && req_ready) n_obs_acc++;
        if (exp_rv && rr) void'(q.pop_front());
        if (acc && we) ref_mem[a] = wd;
        else if (acc) q.push_back('{d: ref_mem[a], due: cyc + 2});
        last_acc = acc;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr);
    endtask

`ifdef RAM_CTRL_INIT_EN
    // Follow the zero-fill sweep from the current cycle; returns early at ic==stop.
    task automatic sweep(input int stop);
        for (int i = 0; i < int'(NPos); i++) begin
            #1;
            check("init_done_sweep", 32'(init_done), 32'd0);
            check("req_ready_sweep", 32'(req_ready), 32'd0);
            check("ram_we_sweep", 32'(ram_we), 32'd1);
            check("ram_a_sweep", 32'(ram_a), 32'(i));
            check("ram_wd_sweep", ram_wd, 32'd0);
            if (i == stop) return;
            @(negedge clk);
        end
        #1;
        check("init_done_rise", 32'(init_done), 32'd1);
        check("req_ready_run", 32'(req_ready), 32'd1);
        for (int i = 0; i < int'(NPos); i++) ref_mem[i] = '0;
    endtask
`endif

    // Assert reset from a point away from the clock edge, hold, release.
    task automatic do_reset(input int stop);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef RAM_CTRL_INIT_EN
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd1);
        check("rst_ram_a", 32'(ram_a), 32'd0);
`else
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd1);
        check("rst_ram_we", 32'(ram_we), 32'd0);
`endif
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
`ifdef RAM_CTRL_INIT_EN
        sweep(stop);
`else
        #1;
        check("post_rst_init_done", 32'(init_done), 32'd1);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        if (stop < 0) ; // no sweep without the zero-fill feature
`endif
    endtask

    initial begin
        int k;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        n_obs_acc = 0;
        last_acc  = 1'b0;
        for (int i = 0; i < int'(NPos); i++) ref_mem[i] = '0;
        #2;

`ifdef RAM_CTRL_INIT_EN
        // Interrupted sweep at ic=7 must restart from address 0.
        do_reset(7);
        do_reset(-1);
        // Zero-filled memory reads back 0.
        step(1'b1, 1'b0, AW'(5), '0, 1'b1);
        idle(3, 1'b1);
`else
        do_reset(-1);
`endif

        // Fill memory with random data.
        for (int a = 0; a < int'(NPos); a++) step(1'b1, 1'b1, AW'(a), $urandom, 1'b1);
        idle(2, 1'b1);

        // Write then read same address in back-to-back cycles.
        step(1'b1, 1'b1, AW'(3), 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, AW'(3), '0, 1'b1);
        idle(3, 1'b1);

        // Back-pressure: only two reads accepted while the consumer stalls.
        step(1'b1, 1'b1, AW'(1), 32'h11, 1'b1);
        step(1'b1, 1'b1, AW'(2), 32'h22, 1'b1);
        step(1'b1, 1'b1, AW'(3), 32'h33, 1'b1);
        n_obs_acc = 0;
        step(1'b1, 1'b0, AW'(1), '0, 1'b0);
        step(1'b1, 1'b0, AW'(2), '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(3), '0, 1'b0);
        check("bp_accepts", 32'(n_obs_acc), 32'd2);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        step(1'b1, 1'b0, AW'(3), '0, 1'b1);
        step(1'b1, 1'b0, AW'(3), '0, 1'b1);
        idle(5, 1'b1);

        // Streaming reads: 6 accepts in 9 cycles from an empty pipe.
        idle(4, 1'b1);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, AW'(k + 4), '0, 1'b1);
            if (last_acc) k++;
        end
        check("stream_accepts", 32'(k), 32'd6);
        idle(4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, NPos - 1)), $urandom, ($urandom_range(0, 3) != 0));
        end
        idle(4, 1'b1);

        // Reset with two responses buffered: nothing stale afterwards.
        step(1'b1, 1'b0, AW'(1), '0, 1'b0);
        step(1'b1, 1'b0, AW'(2), '0, 1'b0);
        idle(3, 1'b0);
        check("buf_full_valid", 32'(rsp_valid), 32'd1);
        do_reset(-1);
        idle(4, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 1) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, NPos - 1)), $urandom, ($urandom_range(0, 2) != 0));
        end
        idle(4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
